program_loader: RTL and testbench

//  Upstream stage of the CPU: receives a program as a byte stream (from the UART receiver),

---
 rtl/program_loader.sv | 167 ++++++++++++++++
 tb/tb_program_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: parses a framed byte stream into instruction words, writes them to
// instruction memory and releases the CPU only after a checksum-valid image has been received.
module program_loader #(
   parameter int         INSTRUCTION_WIDTH = 32,
   parameter int         PC_WIDTH          = 8,
   parameter int         TIMEOUT_CYCLES    = 65535,
   parameter logic [7:0] HEADER_BYTE       = 8'hA5
) (
   input  logic                         clock,
   input  logic                         isResetN,
   input  logic [7:0]                   byteData,
   input  logic                         byteValid,
   output logic                         byteReady,
   output logic                         writeEnable,
   output logic [PC_WIDTH-1:0]          writeAddress,
   output logic [INSTRUCTION_WIDTH-1:0] writeData,
   output logic                         cpuHold,
   output logic                         done,
   output logic                         error
);

   localparam int BYTES_PER_INSTR = (INSTRUCTION_WIDTH + 7) / 8;
   localparam int SHIFT_W         = BYTES_PER_INSTR * 8;
   localparam int BCOUNT_W        = $clog2(BYTES_PER_INSTR + 1);
   localparam int IDLE_W          = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      LENGTH,
      DATA,
      CHECKSUM,
      RUN,
      ERROR
   } loaderState_t;

   loaderState_t                 state, stateNext;
   logic [7:0]                   lengthReg, lengthNext;
   logic [7:0]                   sum, sumNext;
   logic [SHIFT_W-1:0]           shiftWord, shiftNext, assembled;
   logic [BCOUNT_W-1:0]          byteCount, byteCountNext;
   logic [7:0]                   wordCount, wordCountNext;
   logic [PC_WIDTH-1:0]          addr, addrNext;
   logic [IDLE_W-1:0]            idleCount, idleNext;
   logic                         writeEnableNext;
   logic [PC_WIDTH-1:0]          writeAddressNext;
   logic [INSTRUCTION_WIDTH-1:0] writeDataNext;
   logic                         transfer;
   logic                         inFrame;
   logic                         lengthTooBig;

   always_comb begin
      transfer         = byteValid & byteReady;
      inFrame          = (state == LENGTH) || (state == DATA) || (state == CHECKSUM);
      lengthTooBig     = 32'(byteData) > (32'd1 << PC_WIDTH);
      // First byte of a word ends up in the most significant position; pad bits fall off the top.
      assembled        = (shiftWord << 8) | SHIFT_W'(byteData);
      stateNext        = state;
      lengthNext       = lengthReg;
      sumNext          = sum;
      shiftNext        = shiftWord;
      byteCountNext    = byteCount;
      wordCountNext    = wordCount;
      addrNext         = addr;
      idleNext         = idleCount;
      writeEnableNext  = 1'b0;
      writeAddressNext = writeAddress;
      writeDataNext    = writeData;

      case (state)
         IDLE, RUN, ERROR: begin
            if (transfer && byteData == HEADER_BYTE) begin
               stateNext = LENGTH;
               idleNext  = '0;
            end
         end
         LENGTH: begin
            if (transfer) begin
               lengthNext    = byteData;
               sumNext       = byteData;
               addrNext      = '0;
               wordCountNext = '0;
               byteCountNext = '0;
               shiftNext     = '0;
               if (byteData == 8'd0)
                  stateNext = CHECKSUM;
               else if (lengthTooBig)
                  stateNext = ERROR;
               else
                  stateNext = DATA;
            end
         end
         DATA: begin
            if (transfer) begin
               sumNext   = sum + byteData;
               shiftNext = assembled;
               if (byteCount == BCOUNT_W'(BYTES_PER_INSTR - 1)) begin
                  byteCountNext    = '0;
                  writeEnableNext  = 1'b1;
                  writeAddressNext = addr;
                  writeDataNext    = assembled[INSTRUCTION_WIDTH-1:0];
                  addrNext         = addr + 1'b1;
                  wordCountNext    = wordCount + 8'd1;
                  if ((wordCount + 8'd1) == lengthReg)
                     stateNext = CHECKSUM;
               end else begin
                  byteCountNext = byteCount + 1'b1;
               end
            end
         end
         CHECKSUM: begin
            if (transfer)
               stateNext = (byteData == sum) ? RUN : ERROR;
         end
         default: stateNext = IDLE;
      endcase

      // Idle watchdog only runs while a frame is open; a transfer always restarts it.
      if (inFrame && !transfer) begin
         if (idleCount == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            stateNext = ERROR;
            idleNext  = '0;
         end else begin
            idleNext = idleCount + 1'b1;
         end
      end else if (inFrame) begin
         idleNext = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!isResetN) begin
         state        <= IDLE;
         lengthReg    <= '0;
         sum          <= '0;
         shiftWord    <= '0;
         byteCount    <= '0;
         wordCount    <= '0;
         addr         <= '0;
         idleCount    <= '0;
         byteReady    <= 1'b0;
         writeEnable  <= 1'b0;
         writeAddress <= '0;
         writeData    <= '0;
         cpuHold      <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         state        <= stateNext;
         lengthReg    <= lengthNext;
         sum          <= sumNext;
         shiftWord    <= shiftNext;
         byteCount    <= byteCountNext;
         wordCount    <= wordCountNext;
         addr         <= addrNext;
         idleCount    <= idleNext;
         // The memory write cycle is the only time a byte cannot be taken.
         byteReady    <= !writeEnableNext;
         writeEnable  <= writeEnableNext;
         writeAddress <= writeAddressNext;
         writeData    <= writeDataNext;
         cpuHold      <= (stateNext != RUN);
         done         <= (stateNext == RUN);
         error        <= (stateNext == ERROR);
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a frame-level reference model.
module tb_program_loader;

   localparam int IW  = 32;
   localparam int PCW = 4;
   localparam int TO  = 64;
   localparam int MAX_WORDS = 1 << PCW;

   logic           clock = 1'b0;
   logic           isResetN = 1'b0;
   logic [7:0]     byteData = 8'h00;
   logic           byteValid = 1'b0;
   logic           byteReady, writeEnable, cpuHold, done, error;
   logic [PCW-1:0] writeAddress;
   logic [IW-1:0]  writeData;

   int checks = 0;
   int failures = 0;

   logic [7:0]     frame[$];
   logic [PCW-1:0] logAddr[$];
   logic [IW-1:0]  logData[$];
   int             readyDuringWrite = 0;
   logic [PCW-1:0] expAddr[$];
   logic [IW-1:0]  expData[$];
   int             expStatus;   // 1 = image running, 2 = error

   program_loader #(
      .INSTRUCTION_WIDTH(IW),
      .PC_WIDTH(PCW),
      .TIMEOUT_CYCLES(TO),
      .HEADER_BYTE(8'hA5)
   ) dut (
      .clock(clock),
      .isResetN(isResetN),
      .byteData(byteData),
      .byteValid(byteValid),
      .byteReady(byteReady),
      .writeEnable(writeEnable),
      .writeAddress(writeAddress),
      .writeData(writeData),
      .cpuHold(cpuHold),
      .done(done),
      .error(error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (isResetN && writeEnable) begin
         logAddr.push_back(writeAddress);
         logData.push_back(writeData);
         if (byteReady) readyDuringWrite++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic clearLog();
      logAddr.delete();
      logData.delete();
      readyDuringWrite = 0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int waited = 0;
      byteData  = b;
      byteValid = 1'b1;
      @(negedge clock);
      while (!byteReady && waited < 20) begin
         waited++;
         @(negedge clock);
      end
      if (!byteReady) begin
         checks++;
         failures++;
         $display("FAIL sendByte_ready got=%0b want=1", byteReady);
      end
      @(posedge clock);
      #1;
      byteValid = 1'b0;
   endtask

   task automatic stall(input int k);
      repeat (k) @(posedge clock);
      #1;
   endtask

   // gapMode: 0 back-to-back, 1 one idle cycle after every byte, 2 random 0..3 idle cycles
   task automatic sendFrame(input int gapMode);
      foreach (frame[i]) begin
         sendByte(frame[i]);
         if (gapMode == 1) stall(1);
         else if (gapMode == 2) stall($urandom_range(0, 3));
      end
   endtask

   task automatic buildFrame(input int n, input bit badSum);
      int s = n;
      frame.delete();
      frame.push_back(8'hA5);
      frame.push_back(8'(n));
      if (n <= MAX_WORDS) begin
         for (int i = 0; i < n * 4; i++) begin
            logic [7:0] b = 8'($urandom_range(0, 255));
            frame.push_back(b);
            s += b;
         end
         frame.push_back(8'((s % 256) + (badSum ? 1 : 0)));
      end
   endtask

   // Frame-level reference: words are big-endian groups of 4 bytes, checksum is the byte sum.
   task automatic modelFrame();
      int n = frame[1];
      int s = n;
      expAddr.delete();
      expData.delete();
      if (n > MAX_WORDS) begin
         expStatus = 2;
      end else begin
         for (int i = 0; i < n; i++) begin
            logic [IW-1:0] w = '0;
            for (int k = 0; k < 4; k++) begin
               w = w * 256 + IW'(frame[2 + 4 * i + k]);
               s += frame[2 + 4 * i + k];
            end
            expAddr.push_back(PCW'(i));
            expData.push_back(w);
         end
         expStatus = (int'(frame[2 + 4 * n]) == s % 256) ? 1 : 2;
      end
   endtask

   task automatic test_reset();
      isResetN = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (byteReady !== 1'b0) begin failures++; $display("FAIL reset_byteReady got=%0b want=0", byteReady); end
      checks++; if (writeEnable !== 1'b0) begin failures++; $display("FAIL reset_writeEnable got=%0b want=0", writeEnable); end
      checks++; if (writeAddress !== '0) begin failures++; $display("FAIL reset_writeAddress got=%0h want=0", writeAddress); end
      checks++; if (writeData !== '0) begin failures++; $display("FAIL reset_writeData got=%0h want=0", writeData); end
      checks++; if (cpuHold !== 1'b1) begin failures++; $display("FAIL reset_cpuHold got=%0b want=1", cpuHold); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b want=0", error); end
      isResetN = 1'b1;
      stall(1);
      checks++; if (byteReady !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b want=1", byteReady); end
   endtask

   task automatic test_spec_frame(input int gapMode, input bit badSum);
      logic [7:0] fixed[12] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11,
                                8'h00, 8'h00, 8'h00, 8'h22, 8'h35, 8'h00};
      frame.delete();
      for (int i = 0; i < 11; i++) frame.push_back(fixed[i]);
      if (badSum) frame[10] = 8'h36;
      clearLog();
      sendFrame(gapMode);
      checks++; if (logAddr.size() != 2) begin failures++; $display("FAIL spec_write_count got=%0d want=2", logAddr.size()); end
      else begin
         checks++; if (logAddr[0] !== 4'd0 || logData[0] !== 32'h11) begin failures++; $display("FAIL spec_write0 got=%0h:%0h want=0:11", logAddr[0], logData[0]); end
         checks++; if (logAddr[1] !== 4'd1 || logData[1] !== 32'h22) begin failures++; $display("FAIL spec_write1 got=%0h:%0h want=1:22", logAddr[1], logData[1]); end
      end
      checks++; if (readyDuringWrite != 0) begin failures++; $display("FAIL spec_ready_in_write got=%0d want=0", readyDuringWrite); end
      checks++; if (cpuHold !== badSum) begin failures++; $display("FAIL spec_cpuHold got=%0b want=%0b", cpuHold, badSum); end
      checks++; if (done !== !badSum) begin failures++; $display("FAIL spec_done got=%0b want=%0b", done, !badSum); end
      checks++; if (error !== badSum) begin failures++; $display("FAIL spec_error got=%0b want=%0b", error, badSum); end
   endtask

   task automatic test_empty_reload();
      clearLog();
      sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
      checks++; if (logAddr.size() != 0) begin failures++; $display("FAIL empty_writes got=%0d want=0", logAddr.size()); end
      checks++; if (cpuHold !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL empty_run got=%0b%0b want=01", cpuHold, done); end
      sendByte(8'h42);
      checks++; if (cpuHold !== 1'b0) begin failures++; $display("FAIL run_ignore got=%0b want=0", cpuHold); end
      sendByte(8'hA5);
      checks++; if (cpuHold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL reload_hold got=%0b%0b want=10", cpuHold, done); end
      sendByte(8'h00); sendByte(8'h00);
      checks++; if (cpuHold !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL reload_run got=%0b%0b want=01", cpuHold, done); end
   endtask

   task automatic test_timeout();
      clearLog();
      sendByte(8'hA5); sendByte(8'h01); sendByte(8'h12); sendByte(8'h34);
      stall(TO - 1);
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL timeout_early got=%0b want=0", error); end
      sendByte(8'h56); sendByte(8'h78); sendByte(8'h15);
      checks++; if (logAddr.size() != 1 || logData[0] !== 32'h12345678) begin failures++; $display("FAIL timeout_edge_write got=%0d want=1", logAddr.size()); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL timeout_edge_run got=%0b want=1", done); end
      clearLog();
      sendByte(8'hA5); sendByte(8'h01); sendByte(8'h12); sendByte(8'h34);
      stall(TO);
      checks++; if (error !== 1'b1 || cpuHold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL timeout_error got=%0b%0b%0b want=110", error, cpuHold, done); end
      checks++; if (logAddr.size() != 0) begin failures++; $display("FAIL timeout_writes got=%0d want=0", logAddr.size()); end
      sendByte(8'hA5);
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%0b want=0", error); end
      sendByte(8'h01); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h01); sendByte(8'h02);
      checks++; if (logAddr.size() != 1 || logAddr[0] !== 4'd0 || logData[0] !== 32'h1) begin failures++; $display("FAIL recover_write got=%0d want=1", logAddr.size()); end
      checks++; if (done !== 1'b1 || cpuHold !== 1'b0) begin failures++; $display("FAIL recover_run got=%0b%0b want=10", done, cpuHold); end
   endtask

   task automatic test_reset_mid_frame();
      buildFrame(3, 1'b0);
      for (int i = 0; i < 7; i++) sendByte(frame[i]);
      isResetN = 1'b0;
      stall(1);
      checks++; if (byteReady !== 1'b0 || writeEnable !== 1'b0 || cpuHold !== 1'b1 || done !== 1'b0 || error !== 1'b0)
         begin failures++; $display("FAIL midreset_ctrl got=%0b%0b%0b%0b%0b want=00100", byteReady, writeEnable, cpuHold, done, error); end
      checks++; if (writeAddress !== '0 || writeData !== '0) begin failures++; $display("FAIL midreset_data got=%0h:%0h want=0:0", writeAddress, writeData); end
      isResetN = 1'b1;
      stall(1);
      clearLog();
      sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
      checks++; if (logAddr.size() != 0 || cpuHold !== 1'b1 || done !== 1'b0 || error !== 1'b0)
         begin failures++; $display("FAIL idle_ignore got=%0d%0b%0b%0b want=0100", logAddr.size(), cpuHold, done, error); end
      sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL idle_then_frame got=%0b want=1", done); end
   endtask

   task automatic test_random_frames(input int count, input int minN, input int maxN);
      for (int f = 0; f < count; f++) begin
         int n = $urandom_range(minN, maxN);
         bit bad = ($urandom_range(0, 3) == 0);
         buildFrame(n, bad);
         modelFrame();
         clearLog();
         sendFrame($urandom_range(0, 2));
         checks++;
         if (logAddr.size() != expAddr.size()) begin
            failures++; $display("FAIL rand_write_count n=%0d got=%0d want=%0d", n, logAddr.size(), expAddr.size());
         end else begin
            foreach (expAddr[i])
               if (logAddr[i] !== expAddr[i] || logData[i] !== expData[i]) begin
                  failures++; $display("FAIL rand_write n=%0d i=%0d got=%0h:%0h want=%0h:%0h", n, i, logAddr[i], logData[i], expAddr[i], expData[i]);
                  break;
               end
         end
         checks++;
         if (cpuHold !== (expStatus != 1) || done !== (expStatus == 1) || error !== (expStatus == 2)) begin
            failures++; $display("FAIL rand_status n=%0d got=%0b%0b%0b want=%0b%0b%0b", n, cpuHold, done, error, expStatus != 1, expStatus == 1, expStatus == 2);
         end
         checks++; if (readyDuringWrite != 0) begin failures++; $display("FAIL rand_ready_in_write got=%0d want=0", readyDuringWrite); end
      end
   endtask

   initial begin
      test_reset();
      test_spec_frame(0, 1'b0);
      test_spec_frame(0, 1'b1);
      test_empty_reload();
      test_timeout();
      test_reset_mid_frame();
      test_spec_frame(1, 1'b0);
      test_random_frames(2, MAX_WORDS, MAX_WORDS + 1);
      test_random_frames(10, 0, MAX_WORDS + 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
